// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: bus controller state, RAM handshake encoding and pointer sizing
package cpu_types_pkg;
  typedef enum logic [2:0] {ARB, SNOOP, SERVE, WB, IFETCH} bus_state_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester found after ptr, wrapping modulo N
module rr_arbiter
  import cpu_types_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          valid
);
  logic [PW-1:0] idx;
  // scan from ptr+N down to ptr+1 so the nearest requester after ptr wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_coherence_ctrl.sv
// bus_coherence_ctrl: snooping bus arbiter sharing one RAM port among CPUS cores
// BUSCC_C2C_EN: forward snoop hits cache-to-cache with a concurrent writeback;
// when undefined a hit costs a writeback followed by a separate RAM read.
module bus_coherence_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2,
  parameter int AW = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  input  logic [CPUS*AW-1:0]   iaddr,
  input  logic [CPUS*AW-1:0]   daddr,
  input  logic [CPUS*AW-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*AW-1:0]   iload,
  output logic [CPUS*AW-1:0]   dload,
  output logic [CPUS*AW-1:0]   ccsnoopaddr,
  input  logic [1:0]           ramstate,
  input  logic [AW-1:0]        ramload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [AW-1:0]        ramstore
);
  localparam int PW = ptr_w(CPUS);

  bus_state_t state, nstate;
  logic [PW-1:0] dptr, iptr, init, tgt, dgnt, ignt, hit_idx;
  logic dvld, ivld, hit_any, hit, dact, iact, acc;
  logic [CPUS-1:0] others;
`ifndef BUSCC_C2C_EN
  logic wb_done;
`endif

  function automatic logic [AW-1:0] word(input logic [CPUS*AW-1:0] v, input logic [PW-1:0] i);
    return v[int'(i)*AW +: AW];
  endfunction

  rr_arbiter #(.N(CPUS)) u_darb (.req(dREN | dWEN), .ptr(dptr), .grant(dgnt), .valid(dvld));
  rr_arbiter #(.N(CPUS)) u_iarb (.req(iREN), .ptr(iptr), .grant(ignt), .valid(ivld));

  assign dact = dREN[init] | dWEN[init];
  assign iact = iREN[init];
  assign acc = ramstate == ACCESS;
  assign others = ~(CPUS'(1) << init);

  // lowest-numbered other core that holds a modified copy of the snooped line
  always_comb begin
    hit_idx = '0;
    hit_any = 1'b0;
    for (int k = CPUS - 1; k >= 0; k--)
      if (ccwrite[k] && others[k]) begin
        hit_idx = PW'(k);
        hit_any = 1'b1;
      end
  end

  // state register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= ARB;
    else state <= nstate;

  // grant bookkeeping: winner, the pointer it advanced, and the snoop result
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      dptr <= PW'(CPUS - 1);
      iptr <= PW'(CPUS - 1);
      init <= '0;
      tgt <= '0;
      hit <= 1'b0;
    end else begin
      if (state == ARB && dvld) begin
        init <= dgnt;
        dptr <= dgnt;
      end else if (state == ARB && ivld) begin
        init <= ignt;
        iptr <= ignt;
      end
      if (state == SNOOP) begin
        tgt <= hit_idx;
        hit <= hit_any;
      end
    end

`ifndef BUSCC_C2C_EN
  // toggles per word on a hit: writeback landed, then the read for init lands
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) wb_done <= 1'b0;
    else if (state != SERVE) wb_done <= 1'b0;
    else if (hit && dact && acc) wb_done <= ~wb_done;
`endif

  // next state: data beats instruction in ARB; served states hold while init keeps a request open
  always_comb begin
    nstate = state;
    case (state)
      ARB:       nstate = dvld ? (dWEN[dgnt] ? WB : SNOOP) : ivld ? IFETCH : ARB;
      SNOOP:     nstate = SERVE;
      SERVE, WB: nstate = (dact || cctrans[init]) ? state : ARB;
      IFETCH:    nstate = (iact || cctrans[init]) ? IFETCH : ARB;
      default:   nstate = ARB;
    endcase
  end

  // bus, coherence and RAM outputs for the granted core; waits drop only on ACCESS
  always_comb begin
    iwait = '1;
    dwait = '1;
    ccwait = '0;
    ccinv = '0;
    iload = '0;
    dload = '0;
    ccsnoopaddr = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    case (state)
      SNOOP: begin
        ccwait = others;
        ccinv = ccwrite[init] ? others : '0;
        for (int k = 0; k < CPUS; k++)
          if (others[k]) ccsnoopaddr[k*AW +: AW] = word(daddr, init);
      end
      SERVE: begin
        ccwait = others;
        if (dact) begin
          ramREN = 1'b1;
          ramaddr = word(daddr, init);
          dload[int'(init)*AW +: AW] = ramload;
          dwait[init] = !acc;
`ifdef BUSCC_C2C_EN
          if (hit) begin
            ramREN = 1'b0;
            ramWEN = 1'b1;
            ramaddr = word(daddr, tgt);
            ramstore = word(dstore, tgt);
            dload[int'(init)*AW +: AW] = word(dstore, tgt);
            dwait[tgt] = !acc;
          end
`else
          if (hit && !wb_done) begin
            ramREN = 1'b0;
            ramWEN = 1'b1;
            ramaddr = word(daddr, tgt);
            ramstore = word(dstore, tgt);
            dload[int'(init)*AW +: AW] = '0;
            dwait[init] = 1'b1;
            dwait[tgt] = !acc;
          end
`endif
        end
      end
      WB:
        if (dact) begin
          ramWEN = 1'b1;
          ramaddr = word(daddr, init);
          ramstore = word(dstore, init);
          dwait[init] = !acc;
        end
      IFETCH:
        if (iact) begin
          ramREN = 1'b1;
          ramaddr = word(iaddr, init);
          iload[int'(init)*AW +: AW] = ramload;
          iwait[init] = !acc;
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// tb_bus_coherence_ctrl: directed and randomized checks against a transaction-level model
module tb_bus_coherence_ctrl;
  import cpu_types_pkg::*;
  localparam int N = 4;
  localparam int AW = 32;

  logic CLK = 1'b0;
  logic nRST;
  logic [N-1:0] iREN, dREN, dWEN, cctrans, ccwrite, iwait, dwait, ccwait, ccinv;
  logic [N*AW-1:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
  logic [1:0] ramstate;
  logic [AW-1:0] ramload, ramaddr, ramstore;
  logic ramREN, ramWEN;
  int vectors = 0;
  int miscompares = 0;
  int dptr_m, iptr_m;

  always #5 CLK = ~CLK;

  bus_coherence_ctrl #(.CPUS(N), .AW(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans), .ccwrite(ccwrite),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
    .iload(iload), .dload(dload), .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [AW-1:0] slot(input logic [N*AW-1:0] v, input int c);
    return v[c*AW +: AW];
  endfunction

  // round-robin rule: first requester at ptr+1, ptr+2, ... modulo N
  function automatic int pick(input logic [N-1:0] m, input int p);
    logic [1:0] j;
    for (int i = 1; i <= N; i++) begin
      j = 2'((p + i) % N);
      if (m[j]) return int'(j);
    end
    return 0;
  endfunction

  // one granted word for core c; kind 0 read, 1 write, 2 ifetch; starts in the ARB cycle
  task automatic serve(input int c, input int kind, input int lat, input bit err);
    logic [AW-1:0] ld;
    logic [N-1:0] me, nme;
    me = N'(1) << c;
    nme = ~me;
    step();
    ramstate = FREE;
    settle();
    if (kind == 0) begin
      chk("snoop_ccwait", ccwait, nme);
      chk("snoop_ccinv", ccinv, ccwrite[c] ? nme : 4'h0);
      chk("snoop_addr", slot(ccsnoopaddr, (c + 1) % N), slot(daddr, c));
      chk("snoop_ram", {ramREN, ramWEN}, 2'b00);
      step();
    end
    repeat (lat) begin
      ramstate = err ? ERROR : BUSY;
      settle();
      chk("stall_wait", kind == 2 ? iwait : dwait, 4'hF);
      chk("stall_strobe", {ramREN, ramWEN}, kind == 1 ? 2'b01 : 2'b10);
      step();
    end
    ramstate = ACCESS;
    ld = $urandom;
    ramload = ld;
    settle();
    if (kind == 0) begin
      chk("rd_strobe", {ramREN, ramWEN}, 2'b10);
      chk("rd_addr", ramaddr, slot(daddr, c));
      chk("rd_dwait", dwait, nme);
      chk("rd_load", slot(dload, c), ld);
      chk("rd_iwait", iwait, 4'hF);
    end else if (kind == 1) begin
      chk("wr_strobe", {ramREN, ramWEN}, 2'b01);
      chk("wr_addr", ramaddr, slot(daddr, c));
      chk("wr_store", ramstore, slot(dstore, c));
      chk("wr_dwait", dwait, nme);
    end else begin
      chk("if_strobe", {ramREN, ramWEN}, 2'b10);
      chk("if_addr", ramaddr, slot(iaddr, c));
      chk("if_load", slot(iload, c), ld);
      chk("if_iwait", iwait, nme);
      chk("if_dwait", dwait, 4'hF);
    end
    step();
    ramstate = FREE;
    if (kind == 2) iREN[c] = 1'b0;
    else begin
      dREN[c] = 1'b0;
      dWEN[c] = 1'b0;
    end
    step();
    settle();
    chk("arb_waits", {iwait, dwait}, 8'hFF);
    chk("arb_idle", {ramREN, ramWEN, ccwait}, 6'h00);
  endtask

  // raise all requests at once, then serve them in the order the model predicts
  task automatic round(input logic [N-1:0] dm, input logic [N-1:0] wm, input logic [N-1:0] im, input int lat, input bit err);
    logic [N-1:0] dp, ip;
    int c, l;
    for (int k = 0; k < N; k++) begin
      daddr[k*AW +: AW] = $urandom;
      dstore[k*AW +: AW] = $urandom;
      iaddr[k*AW +: AW] = $urandom;
    end
    dREN = dm & ~wm;
    dWEN = dm & wm;
    iREN = im;
    dp = dm;
    ip = im;
    while (dp != 0 || ip != 0) begin
      l = lat < 0 ? int'($urandom_range(0, 3)) : lat;
      if (dp != 0) begin
        c = pick(dp, dptr_m);
        dptr_m = c;
        dp[c] = 1'b0;
        serve(c, wm[c] ? 1 : 0, l, err);
      end else begin
        c = pick(ip, iptr_m);
        iptr_m = c;
        ip[c] = 1'b0;
        serve(c, 2, l, err);
      end
    end
  endtask

  initial begin
    logic [AW-1:0] ld;
    nRST = 1'b0;
    iREN = '0;
    dREN = '0;
    dWEN = '0;
    cctrans = '0;
    ccwrite = '0;
    iaddr = '0;
    daddr = '0;
    dstore = '0;
    ramstate = FREE;
    ramload = '0;
    dptr_m = N - 1;
    iptr_m = N - 1;
    #12;
    chk("rst_waits", {iwait, dwait}, 8'hFF);
    chk("rst_ram", {ramREN, ramWEN}, 2'b00);
    chk("rst_cc", {ccwait, ccinv}, 8'h00);
    chk("rst_addr", ramaddr, 32'h0);
    chk("rst_dload", slot(dload, 0), 32'h0);
    nRST = 1'b1;

    round(4'b0011, 4'b0000, 4'b0000, 1, 1'b0);
    round(4'b1010, 4'b0000, 4'b0000, 0, 1'b0);
    round(4'b0010, 4'b0000, 4'b0001, 1, 1'b0);
    round(4'b0001, 4'b0001, 4'b0000, 5, 1'b1);
    ccwrite = 4'b0100;
    round(4'b0100, 4'b0000, 4'b0000, 0, 1'b0);
    ccwrite = 4'b0000;

    // snoop hit: core 0 reads 0x100 while core 1 holds it modified
    daddr[0 +: AW] = 32'h100;
    daddr[AW +: AW] = 32'h100;
    dstore[AW +: AW] = 32'hCAFE;
    ccwrite = 4'b0010;
    dREN = 4'b0001;
    dptr_m = 0;
    step();
    settle();
    chk("hit_snoop_ccwait", ccwait, 4'b1110);
    step();
`ifdef BUSCC_C2C_EN
    ramstate = ACCESS;
    ramload = 32'h5555;
    settle();
    chk("c2c_strobe", {ramREN, ramWEN}, 2'b01);
    chk("c2c_addr", ramaddr, 32'h100);
    chk("c2c_store", ramstore, 32'hCAFE);
    chk("c2c_load", slot(dload, 0), 32'hCAFE);
    chk("c2c_dwait", dwait, 4'b1100);
`else
    ramstate = ACCESS;
    settle();
    chk("hit_wb_strobe", {ramREN, ramWEN}, 2'b01);
    chk("hit_wb_addr", ramaddr, 32'h100);
    chk("hit_wb_store", ramstore, 32'hCAFE);
    chk("hit_wb_dwait", dwait, 4'b1101);
    step();
    ld = $urandom;
    ramload = ld;
    settle();
    chk("hit_rd_strobe", {ramREN, ramWEN}, 2'b10);
    chk("hit_rd_addr", ramaddr, 32'h100);
    chk("hit_rd_load", slot(dload, 0), ld);
    chk("hit_rd_dwait", dwait, 4'b1110);
`endif
    step();
    ramstate = FREE;
    dREN = '0;
    ccwrite = '0;
    step();
    settle();
    chk("hit_arb", {ramREN, ramWEN, iwait, dwait}, 10'h0FF);

    // reset while serving a read
    dREN = 4'b0100;
    step();
    step();
    ramstate = BUSY;
    settle();
    chk("pre_rst_ren", ramREN, 1'b1);
    nRST = 1'b0;
    settle();
    chk("rst_async", {ramREN, ramWEN, iwait, dwait}, 10'h0FF);
    step();
    settle();
    chk("rst_next", {ramREN, ramWEN, iwait, dwait}, 10'h0FF);
    dREN = '0;
    ramstate = FREE;
    nRST = 1'b1;
    dptr_m = N - 1;
    iptr_m = N - 1;
    round(4'b0101, 4'b0000, 4'b0000, 0, 1'b0);

    for (int r = 0; r < 12; r++)
      round(N'($urandom), N'($urandom), N'($urandom), -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bus_coherence_ctrl.md
BUS_COHERENCE_CTRL -- requirements
Module: bus_coherence_ctrl

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of cores on the bus (2..8).
REQ-002 SHALL have parameter AW, default 32, address and data word width.
REQ-003 SHALL have these ports (N=CPUS):
- CLK  in  1  clock; one clock domain.
- nRST  in  1  asynchronous active-low reset.
- iREN, dREN, dWEN, cctrans, ccwrite  in  N  per-core request and coherence flags.
- iaddr, daddr, dstore  in  N*AW  per-core address and store data.
- iwait, dwait, ccwait, ccinv  out  N  per-core wait and coherence controls.
- iload, dload, ccsnoopaddr  out  N*AW  per-core load data and snoop address.
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR.
- ramload  in  AW  RAM read data.
- ramREN, ramWEN  out  1  RAM strobes.
- ramaddr, ramstore  out  AW  RAM address and write data.

Function
REQ-004 SHALL implement states ARB, SNOOP, SERVE, WB, IFETCH.
REQ-005 ARB: data requests (dREN|dWEN of any core) SHALL beat instruction requests (iREN).
REQ-006 Data winner SHALL be round-robin from dptr: first requester at index dptr+1, dptr+2, ... modulo CPUS. Instruction winner uses iptr the same way.
REQ-007 On grant SHALL latch init and set the used pointer to init, leaving the other pointer unchanged.
REQ-008 Data grant with dWEN[init]=1 SHALL go to WB; with dREN[init]=1 SHALL go to SNOOP; instruction grant SHALL go to IFETCH.
REQ-009 SNOOP SHALL last exactly 1 cycle.
- ccsnoopaddr[k]=daddr[init] and ccinv[k]=ccwrite[init] for every k!=init.
- Then SERVE.
REQ-010 SERVE with any k!=init having ccwrite[k]=1: the lowest such k SHALL be latched as tgt (snoop hit).
- ramWEN=1, ramaddr=daddr[tgt], ramstore=dstore[tgt], dload[init]=dstore[tgt].
REQ-011 SERVE with no hit SHALL drive ramREN=1, ramaddr=daddr[init], dload[init]=ramload.
REQ-012 WB SHALL drive ramWEN=1, ramaddr=daddr[init], ramstore=dstore[init].
REQ-013 IFETCH SHALL drive ramREN=1, ramaddr=iaddr[init], iload[init]=ramload.
REQ-014 dwait/iwait of the served core (and of tgt on a hit) SHALL be 0 only in a cycle where ramstate==ACCESS; otherwise 1.
REQ-015 ramstate FREE/BUSY/ERROR SHALL hold all waits at 1 and keep the state; ERROR SHALL NOT abort.
REQ-016 From SNOOP entry until return to ARB, ccwait SHALL be 1 for every core except init.
REQ-017 SERVE, WB and IFETCH SHALL exit to ARB in the cycle after the init request (dREN/dWEN or iREN) and cctrans[init] are all 0. This allows multi-word blocks under one grant.
REQ-018 A request withdrawn in ARB before grant SHALL be ignored; requests from non-granted cores SHALL wait.
REQ-019 Outside a granted ACCESS, iwait/dwait SHALL be all-ones, and ccwait/ccinv/loads/snoopaddr/ram outputs SHALL be 0.

Reset
REQ-020 nRST low SHALL asynchronously force state=ARB, dptr=iptr=CPUS-1, init=tgt=0; all outputs per REQ-019.
REQ-021 Reset mid-transaction SHALL drop the transaction with no RAM strobe in the following cycle; core 0 SHALL have priority on the first grant after reset.

Configuration
REQ-022 Macro BUSCC_C2C_EN SHALL select the snoop-hit behaviour.
- Defined: REQ-010 applies; cache-to-cache forward plus concurrent writeback in one RAM access per word.
- Undefined: a hit SHALL first perform the tgt writeback (dwait[tgt] released on ACCESS) and then a RAM read for init.
- Undefined: dload[init]=ramload, costing two RAM accesses per word.

Structure
REQ-023 State enum and pointer width ($clog2(CPUS)) SHALL live in shared package cpu_types_pkg; ramstate_t SHALL be reused from it.
REQ-024 The round-robin picker SHALL be sub-module rr_arbiter (inputs req[N], ptr; output grant index, valid), instantiated twice.

Verification
REQ-025 CPUS=2; cores 0 and 1 assert dREN from reset -> core 0 served first, then core 1; dptr=1 after.
REQ-026 CPUS=4; dREN on cores 1 and 3 with dptr=1 -> core 3 granted; ccwait=4'b0111.
REQ-027 Core 0 dREN daddr=0x100, core 1 ccwrite=1 with dstore=0xCAFE -> C2C_EN: dload[0]=0xCAFE, ramWEN=1 at ramaddr=0x100 in the same ACCESS. Without C2C_EN: write then read.
REQ-028 iREN[0] and dREN[1] in the same cycle -> data granted first; IFETCH follows; iload[0]=ramload on ACCESS.
REQ-029 ramstate=ERROR for 5 cycles during WB -> dwait stays 1 and state stays WB; completes on the later ACCESS.
REQ-030 nRST asserted in SERVE -> next cycle ARB, ramREN=ramWEN=0, all waits 1.
